// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle sequencer: FSM states, opcodes,
// mux encodings and the decoded opcode class.
package ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StExecR,
        StWbR,
        StExecI,
        StWbI,
        StMemAddr,
        StMemRd,
        StMemWb,
        StMemWr,
        StBranch,
        StJump,
        StTrap
    } state_e;

    localparam logic [5:0] OpAnd  = 6'b100000;
    localparam logic [5:0] OpNor  = 6'b100110;
    localparam logic [5:0] OpNot  = 6'b000100;
    localparam logic [5:0] OpRolv = 6'b000000;
    localparam logic [5:0] OpRorv = 6'b000010;
    localparam logic [5:0] OpNori = 6'b001110;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpBleu = 6'b010000;
    localparam logic [5:0] OpJr   = 6'b001000;
    localparam logic [5:0] OpJal  = 6'b000011;

    localparam logic [1:0] AluBReg  = 2'b00;
    localparam logic [1:0] AluBImm  = 2'b10;
    localparam logic [1:0] AluBJump = 2'b11;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcJal    = 2'b01;
    localparam logic [1:0] PcBranch = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;

    // Exactly one field is set for any opcode.
    typedef struct packed {
        logic rtype;
        logic itype;
        logic lw;
        logic sw;
        logic bleu;
        logic jr;
        logic jal;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Control bus between the sequencer (master) and the multicycle datapath (slave).
interface multicycle_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             alu_flag;
    logic             mem_req;
    logic             iord;
    logic             ir_write;
    logic             pc_write;
    logic             mem_write;
    logic             reg_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [4:0]       alu_control;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready, alu_flag,
        output mem_req, iord, ir_write, pc_write, mem_write, reg_write, mem_to_reg,
               reg_dst, alu_src_a, alu_src_b, pc_src, alu_control, illegal, retired
    );

    modport slave (
        output opcode, mem_ready, alu_flag,
        input  mem_req, iord, ir_write, pc_write, mem_write, reg_write, mem_to_reg,
               reg_dst, alu_src_a, alu_src_b, pc_src, alu_control, illegal, retired
    );
endinterface

// File: rtl/op_decode.sv
// Combinational opcode classifier producing a one-hot class vector.
module op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OpAnd, OpNor, OpNot, OpRolv, OpRorv: op_class.rtype = 1'b1;
            OpNori:                              op_class.itype = 1'b1;
            OpLw:                                op_class.lw    = 1'b1;
            OpSw:                                op_class.sw    = 1'b1;
            OpBleu:                              op_class.bleu  = 1'b1;
            OpJr:                                op_class.jr    = 1'b1;
            OpJal:                               op_class.jal   = 1'b1;
            default:                             op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle datapath controller: encoded-state FSM with memory stall handshake,
// datapath control decode and a retired-instruction counter.
module multicycle_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic                   clock,
    input logic                   reset,
    multicycle_sequencer_if.master bus
);

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retired_q;
    logic             illegal_q;
    logic             retire;
    op_class_t        op_class;

    op_decode u_op_decode (
        .opcode   (bus.opcode),
        .op_class (op_class)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            StFetch:   if (bus.mem_ready) state_d = StDecode;
            StDecode: begin
                if (op_class.rtype)                    state_d = StExecR;
                else if (op_class.itype)               state_d = StExecI;
                else if (op_class.lw || op_class.sw)   state_d = StMemAddr;
                else if (op_class.bleu)                state_d = StBranch;
                else if (op_class.jr || op_class.jal)  state_d = StJump;
                else                                   state_d = StTrap;
            end
            StExecR:   state_d = StWbR;
            StExecI:   state_d = StWbI;
            StMemAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:   if (bus.mem_ready) state_d = StMemWb;
            StMemWr: begin
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWbR, StWbI, StMemWb, StBranch, StJump: begin
                state_d = StFetch;
                retire  = 1'b1;
            end
            StTrap:    state_d = StTrap;
            default:   state_d = StFetch;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.alu_src_b  = AluBReg;
        bus.pc_src     = PcPlus4;
        // Gated by reset so no strobe or request escapes while the FSM sits in FETCH.
        if (!reset) begin
            unique case (state_q)
                StFetch: begin
                    bus.mem_req  = 1'b1;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                StWbR: begin
                    bus.reg_write = 1'b1;
                    bus.reg_dst   = 1'b1;
                end
                StExecI, StMemAddr: bus.alu_src_b = AluBImm;
                StWbI: begin
                    bus.reg_write = 1'b1;
                    bus.alu_src_b = AluBImm;
                end
                StMemRd, StMemWr: begin
                    bus.mem_req   = 1'b1;
                    bus.iord      = 1'b1;
                    bus.alu_src_b = AluBImm;
                    bus.mem_write = (state_q == StMemWr) && bus.mem_ready;
                end
                StMemWb: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = 1'b1;
                end
                StBranch: begin
                    bus.pc_src   = PcBranch;
                    bus.pc_write = bus.alu_flag;
                end
                StJump: begin
                    bus.pc_write  = 1'b1;
                    bus.alu_src_b = AluBJump;
                    if (op_q == OpJal) begin
                        bus.pc_src     = PcJal;
                        bus.reg_write  = 1'b1;
                        bus.mem_to_reg = 1'b1;
                    end else begin
                        bus.pc_src = PcReg;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_src_a   = 1'b1;
    assign bus.alu_control = op_q[5:1];
    assign bus.illegal     = illegal_q;
    assign bus.retired     = retired_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            op_q      <= '0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) op_q <= bus.opcode;
            if (retire) retired_q <= retired_q + CNT_W'(1);
            if (state_d == StTrap) illegal_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus queues hand-computed per-cycle outputs, a monitor compares them.
module tb_multicycle_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;

    multicycle_sequencer_if #(.CNT_W(32)) bus ();

    multicycle_sequencer #(.CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // strb order: mem_req iord ir_write pc_write mem_write reg_write mem_to_reg reg_dst alu_src_a
    typedef struct packed {
        logic [8:0]  strb;
        logic [1:0]  srcb;
        logic [1:0]  pcs;
        logic [4:0]  aluc;
        logic        ill;
        logic [31:0] ret;
    } obs_t;

    typedef struct {
        obs_t  v;
        string tag;
    } exp_t;

    localparam logic [8:0] SIdle    = 9'b000000001;
    localparam logic [8:0] SFetchOk = 9'b101100001;
    localparam logic [8:0] SFetchSt = 9'b100000001;
    localparam logic [8:0] SWbR     = 9'b000001011;
    localparam logic [8:0] SWbI     = 9'b000001001;
    localparam logic [8:0] SMemRd   = 9'b110000001;
    localparam logic [8:0] SMemWb   = 9'b000001101;
    localparam logic [8:0] SMemWr   = 9'b110010001;
    localparam logic [8:0] SPcWr    = 9'b000100001;
    localparam logic [8:0] SJal     = 9'b000101101;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [5:0]  exp_op = '0;
    logic        exp_ill = 1'b0;
    logic [31:0] exp_ret = '0;
    event        sample_ev;

    function automatic obs_t sample();
        obs_t o;
        o.strb = {bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.mem_write,
                  bus.reg_write, bus.mem_to_reg, bus.reg_dst, bus.alu_src_a};
        o.srcb = bus.alu_src_b;
        o.pcs  = bus.pc_src;
        o.aluc = bus.alu_control;
        o.ill  = bus.illegal;
        o.ret  = bus.retired;
        return o;
    endfunction

    task automatic push(input string tag, input logic [8:0] strb, input logic [1:0] srcb,
                        input logic [1:0] pcs);
        exp_t e;
        e.v   = '{strb, srcb, pcs, exp_op[5:1], exp_ill, exp_ret};
        e.tag = tag;
        sb.push_back(e);
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, advance past the edge.
    task automatic step(input string tag, input logic mr, input logic af, input logic [8:0] strb,
                        input logic [1:0] srcb, input logic [1:0] pcs, input logic ret);
        bus.mem_ready = mr;
        bus.alu_flag  = af;
        push(tag, strb, srcb, pcs);
        @(posedge clock);
        #1;
        if (ret) exp_ret = exp_ret + 1;
    endtask

    task automatic fetch(input logic [5:0] op);
        bus.opcode = op;
        step("fetch", 1'b1, 1'b0, SFetchOk, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic decode();
        step("decode", 1'b1, 1'b0, SIdle, 2'b00, 2'b00, 1'b0);
        exp_op = bus.opcode;
    endtask

    task automatic reset_now(input string tag);
        reset = 1'b1;
        #1;
        exp_ret = '0;
        exp_ill = 1'b0;
        exp_op  = '0;
        push(tag, SIdle, 2'b00, 2'b00);
        -> sample_ev;
    endtask

    initial begin : monitor
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clock or sample_ev);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = sample();
                vectors++;
                if (a !== e.v) begin
                    miscompares++;
                    $display("FAIL %s: got %h, expected %h", e.tag, a, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        bus.alu_flag  = 1'b0;
        @(posedge clock);
        #1;
        push("reset_hold", SIdle, 2'b00, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // and: 4 cycles
        fetch(6'b100000);
        decode();
        step("exec_r", 1'b1, 1'b0, SIdle, 2'b00, 2'b00, 1'b0);
        step("wb_r", 1'b1, 1'b0, SWbR, 2'b00, 2'b00, 1'b1);

        // nori
        fetch(6'b001110);
        decode();
        step("exec_i", 1'b1, 1'b0, SIdle, 2'b10, 2'b00, 1'b0);
        step("wb_i", 1'b1, 1'b0, SWbI, 2'b10, 2'b00, 1'b1);

        // rorv with one fetch wait cycle
        bus.opcode = 6'b000010;
        step("fetch_stall", 1'b0, 1'b0, SFetchSt, 2'b00, 2'b00, 1'b0);
        fetch(6'b000010);
        decode();
        step("exec_r", 1'b1, 1'b0, SIdle, 2'b00, 2'b00, 1'b0);
        step("wb_r", 1'b1, 1'b0, SWbR, 2'b00, 2'b00, 1'b1);

        // lw with two MEM_RD wait cycles: 7 cycles
        fetch(6'b100011);
        decode();
        step("mem_addr", 1'b1, 1'b0, SIdle, 2'b10, 2'b00, 1'b0);
        step("mem_rd_stall", 1'b0, 1'b0, SMemRd, 2'b10, 2'b00, 1'b0);
        step("mem_rd_stall", 1'b0, 1'b0, SMemRd, 2'b10, 2'b00, 1'b0);
        step("mem_rd_done", 1'b1, 1'b0, SMemRd, 2'b10, 2'b00, 1'b0);
        step("mem_wb", 1'b1, 1'b0, SMemWb, 2'b00, 2'b00, 1'b1);

        // sw
        fetch(6'b101011);
        decode();
        step("mem_addr", 1'b1, 1'b0, SIdle, 2'b10, 2'b00, 1'b0);
        step("mem_wr", 1'b1, 1'b0, SMemWr, 2'b10, 2'b00, 1'b1);

        // bleu taken then not taken
        fetch(6'b010000);
        decode();
        step("branch_taken", 1'b1, 1'b1, SPcWr, 2'b00, 2'b10, 1'b1);
        fetch(6'b010000);
        decode();
        step("branch_not_taken", 1'b1, 1'b0, SIdle, 2'b00, 2'b10, 1'b1);

        // jal then jr
        fetch(6'b000011);
        decode();
        step("jump_jal", 1'b1, 1'b0, SJal, 2'b11, 2'b01, 1'b1);
        fetch(6'b001000);
        decode();
        step("jump_jr", 1'b1, 1'b0, SPcWr, 2'b11, 2'b11, 1'b1);

        // illegal opcode: TRAP, sticky flag, ignores memory
        fetch(6'b111111);
        decode();
        exp_ill = 1'b1;
        step("trap", 1'b1, 1'b0, SIdle, 2'b00, 2'b00, 1'b0);
        step("trap_sticky", 1'b1, 1'b1, SIdle, 2'b00, 2'b00, 1'b0);
        reset_now("reset_from_trap");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // lw aborted by asynchronous reset during a MEM_RD stall
        fetch(6'b100011);
        decode();
        step("mem_addr", 1'b1, 1'b0, SIdle, 2'b10, 2'b00, 1'b0);
        step("mem_rd_stall", 1'b0, 1'b0, SMemRd, 2'b10, 2'b00, 1'b0);
        push("mem_rd_stall", SMemRd, 2'b10, 2'b00);
        @(negedge clock);
        #1;
        reset_now("reset_mid_stall");
        @(posedge clock);
        #1;
        push("reset_held", SIdle, 2'b00, 2'b00);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // rolv after recovery, then next fetch shows retired = 1
        fetch(6'b000000);
        decode();
        step("exec_r", 1'b1, 1'b0, SIdle, 2'b00, 2'b00, 1'b0);
        step("wb_r", 1'b1, 1'b0, SWbR, 2'b00, 2'b00, 1'b1);
        fetch(6'b100110);

        @(negedge clock);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
